// File: rtl/divider_pkg.sv
// ----------------------------------------------------------------------------
// divider_pkg
// Shared types and constants for the seq_divider block: FSM state
// encoding and the shift-counter width helper.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package divider_pkg;

  // Explicit state encoding, kept as named constants so the enum below and
  // any debug tooling agree on the binary values.
  localparam int         STATE_W                  = 3;
  localparam logic [2:0] C_WAIT_FOR_START         = 3'd0;
  localparam logic [2:0] C_CHECK_DIVIDE_BY_ZERO   = 3'd1;
  localparam logic [2:0] C_ERROR                  = 3'd2;
  localparam logic [2:0] C_SHIFT_LEFT             = 3'd3;
  localparam logic [2:0] C_SHIFT_RIGHT            = 3'd4;
  localparam logic [2:0] C_NO_ERROR               = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    WAIT_FOR_START       = C_WAIT_FOR_START,
    CHECK_DIVIDE_BY_ZERO = C_CHECK_DIVIDE_BY_ZERO,
    ERROR                = C_ERROR,
    SHIFT_LEFT           = C_SHIFT_LEFT,
    SHIFT_RIGHT          = C_SHIFT_RIGHT,
    NO_ERROR             = C_NO_ERROR
  } state_t;

  // The counter must reach SIZE-1 left shifts; one extra bit keeps the
  // range comfortable for every SIZE >= 2.
  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
// Start/done handshake bundle between a host (master) and the divider
// (slave). Optional DIVIDER_BUSY_EN adds a busy status line.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if #(
  parameter int SIZE = 8
);

  logic            start;
  logic [SIZE-1:0] dividend;
  logic [SIZE-1:0] divisor;
  logic            error;
  logic            done;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;

`ifdef DIVIDER_BUSY_EN
  logic            busy;

  modport master (
    output start, dividend, divisor,
    input  error, done, quotient, remainder, busy
  );

  modport slave (
    input  start, dividend, divisor,
    output error, done, quotient, remainder, busy
  );
`else
  modport master (
    output start, dividend, divisor,
    input  error, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output error, done, quotient, remainder
  );
`endif

endinterface

`default_nettype wire

// File: rtl/divider_datapath.sv
// ----------------------------------------------------------------------------
// divider_datapath
// Restoring-division datapath: partial remainder, quotient, shifted divisor
// and shift counter, steered by the init/left/right/sub strobes from the
// controlling FSM. Returns the status flags the FSM branches on.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module divider_datapath
  import divider_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init_i,
  input  logic            left_i,
  input  logic            right_i,
  input  logic            sub_i,
  input  logic            quo_shift_i,
  input  logic [SIZE-1:0] dividend_i,
  input  logic [SIZE-1:0] divisor_i,
  output logic [SIZE-1:0] quotient_o,
  output logic [SIZE-1:0] remainder_o,
  output logic            cnt_is_0_o,
  output logic            divisor_is_0_o,
  output logic            dvsr_less_than_dvnd_o,
  output logic            shifted_divisor_msb_o,
  output logic            dvsr_le_rem_o
);

  localparam int CNT_W = cnt_width(SIZE);

  logic [SIZE-1:0]  rem_q,  rem_d;
  logic [SIZE-1:0]  quo_q,  quo_d;
  logic [SIZE-1:0]  dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Status decodes; dvsr_le_rem is the restoring "fits" test and doubles
  // as the next quotient bit.
  assign cnt_is_0_o            = (cnt_q == '0);
  assign divisor_is_0_o        = (dvsr_q == '0);
  assign dvsr_less_than_dvnd_o = (dvsr_q < rem_q);
  assign shifted_divisor_msb_o = dvsr_q[SIZE-1];
  assign dvsr_le_rem_o         = (dvsr_q <= rem_q);

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // Next-state steering of the datapath registers from the FSM strobes.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (init_i) begin
      rem_d  = dividend_i;
      dvsr_d = divisor_i;
      quo_d  = '0;
      cnt_d  = '0;
    end else begin
      if (left_i) begin
        dvsr_d = dvsr_q << 1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      if (right_i) begin
        dvsr_d = dvsr_q >> 1;
        cnt_d  = cnt_q - CNT_W'(1);
      end
      if (sub_i) begin
        rem_d = rem_q - dvsr_q;
      end
      // The quotient bit shifted in is exactly "a subtraction happened".
      if (quo_shift_i) begin
        quo_d = {quo_q[SIZE-2:0], sub_i};
      end
    end
  end

  // Datapath register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Sequential unsigned restoring divider behind a start/done handshake.
// Divide-by-zero is detected in one cycle and reported with error+done.
// Optional feature macro: DIVIDER_BUSY_EN adds a registered busy output.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_divider
  import divider_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  state_t state_q, state_d;
  logic   done_q;
  logic   error_q;

  // Datapath strobes and status.
  logic init;
  logic left;
  logic right;
  logic sub;
  logic quo_shift;
  logic cnt_is_0;
  logic divisor_is_0;
  logic dvsr_less_than_dvnd;
  logic shifted_divisor_msb;
  logic dvsr_le_rem;

  divider_datapath #(
    .SIZE (SIZE)
  ) u_datapath (
    .clk                   (clk),
    .reset                 (reset),
    .init_i                (init),
    .left_i                (left),
    .right_i               (right),
    .sub_i                 (sub),
    .quo_shift_i           (quo_shift),
    .dividend_i            (bus.dividend),
    .divisor_i             (bus.divisor),
    .quotient_o            (bus.quotient),
    .remainder_o           (bus.remainder),
    .cnt_is_0_o            (cnt_is_0),
    .divisor_is_0_o        (divisor_is_0),
    .dvsr_less_than_dvnd_o (dvsr_less_than_dvnd),
    .shifted_divisor_msb_o (shifted_divisor_msb),
    .dvsr_le_rem_o         (dvsr_le_rem)
  );

  // Next-state and strobe decode; start is only looked at when idle.
  always_comb begin
    state_d   = state_q;
    init      = 1'b0;
    left      = 1'b0;
    right     = 1'b0;
    sub       = 1'b0;
    quo_shift = 1'b0;
    case (state_q)
      WAIT_FOR_START: begin
        if (bus.start) begin
          init    = 1'b1;
          state_d = CHECK_DIVIDE_BY_ZERO;
        end
      end
      CHECK_DIVIDE_BY_ZERO: begin
        state_d = divisor_is_0 ? ERROR : SHIFT_LEFT;
      end
      SHIFT_LEFT: begin
        // Align the divisor just above the dividend without losing its MSB.
        if (!shifted_divisor_msb && dvsr_less_than_dvnd) begin
          left = 1'b1;
        end else begin
          state_d = SHIFT_RIGHT;
        end
      end
      SHIFT_RIGHT: begin
        quo_shift = 1'b1;
        sub       = dvsr_le_rem;
        if (cnt_is_0) begin
          state_d = NO_ERROR;
        end else begin
          right = 1'b1;
        end
      end
      ERROR, NO_ERROR: begin
        state_d = WAIT_FOR_START;
      end
      default: begin
        state_d = WAIT_FOR_START;
      end
    endcase
  end

  // State register with done/error registered from the next state so they
  // are clean single-cycle pulses aligned with ERROR/NO_ERROR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_FOR_START;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ERROR) || (state_d == NO_ERROR);
      error_q <= (state_d == ERROR);
    end
  end

  assign bus.done  = done_q;
  assign bus.error = error_q;

`ifdef DIVIDER_BUSY_EN
  logic busy_q;

  // Busy covers exactly the working states, registered like done/error.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_d == CHECK_DIVIDE_BY_ZERO) ||
                (state_d == SHIFT_LEFT) ||
                (state_d == SHIFT_RIGHT);
    end
  end

  assign bus.busy = busy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider at SIZE=8 and SIZE=2, scoreboard
// driven: expectations are queued at start and popped at done.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;
  import divider_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8;
  logic rst2;

  seq_divider_if #(.SIZE(8)) if8 ();
  seq_divider_if #(.SIZE(2)) if2 ();

  seq_divider #(.SIZE(8)) dut8 (.clk(clk), .reset(rst8), .bus(if8.slave));
  seq_divider #(.SIZE(2)) dut2 (.clk(clk), .reset(rst2), .bus(if2.slave));

  typedef struct {
    int q;
    int r;
    bit e;
    int lat;
  } exp_t;

  exp_t sb8[$];
  exp_t sb2[$];
  int   total = 0;
  int   bad   = 0;
  bit   saw_sub_right;

  // Reference: arithmetic result plus edges from accepting edge to the edge
  // after which done is visible (error: 1; normal: 1 + (k+1) + (k+1)).
  function automatic exp_t model(input int a, input int b, input int sz);
    exp_t x;
    int   d;
    int   k;
    if (b == 0) begin
      x.q = 0; x.r = a; x.e = 1'b1; x.lat = 1;
    end else begin
      x.q = a / b; x.r = a % b; x.e = 1'b0;
      d = b; k = 0;
      while ((((d >> (sz - 1)) & 1) == 0) && (d < a)) begin
        d = d << 1;
        k++;
      end
      x.lat = 2 * k + 3;
    end
    return x;
  endfunction

  task automatic run8(input int a, input int b, input bit hold_start);
    exp_t x;
    int   cyc;
    logic [7:0] qv;
    logic [7:0] rv;
    if8.start = 1'b1; if8.dividend = a[7:0]; if8.divisor = b[7:0];
    sb8.push_back(model(a, b, 8));
    @(posedge clk); #1;
    // Operand churn after acceptance must not matter; optional start hold
    // must be ignored while busy.
    if8.start = hold_start; if8.dividend = 8'hA5; if8.divisor = 8'h03;
    cyc = 0;
    while (if8.done !== 1'b1 && cyc < 60) begin
      if (dut8.sub === 1'b1 && dut8.right === 1'b1) saw_sub_right = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if8.start = 1'b0;
    x = sb8.pop_front();
    qv = x.q[7:0];
    rv = x.r[7:0];
    total++;
    if (if8.done !== 1'b1) begin
      bad++; $display("FAIL done8 %0d/%0d: done=%b after %0d cycles, required 1", a, b, if8.done, cyc);
    end
    total++;
    if (cyc !== x.lat) begin
      bad++; $display("FAIL latency8 %0d/%0d: got %0d required %0d", a, b, cyc, x.lat);
    end
    total++;
    if (if8.quotient !== qv) begin
      bad++; $display("FAIL quotient8 %0d/%0d: got %0d required %0d", a, b, if8.quotient, qv);
    end
    total++;
    if (if8.remainder !== rv) begin
      bad++; $display("FAIL remainder8 %0d/%0d: got %0d required %0d", a, b, if8.remainder, rv);
    end
    total++;
    if (if8.error !== x.e) begin
      bad++; $display("FAIL error8 %0d/%0d: got %b required %b", a, b, if8.error, x.e);
    end
    @(posedge clk); #1;
    total++;
    if (if8.done !== 1'b0 || if8.error !== 1'b0) begin
      bad++; $display("FAIL pulse8 %0d/%0d: done=%b error=%b required 0 0", a, b, if8.done, if8.error);
    end
    total++;
    if (if8.quotient !== qv || if8.remainder !== rv) begin
      bad++; $display("FAIL hold8 %0d/%0d: got %0d r %0d required %0d r %0d", a, b, if8.quotient, if8.remainder, qv, rv);
    end
  endtask

  task automatic run2(input int a, input int b);
    exp_t x;
    int   cyc;
    logic [1:0] qv;
    logic [1:0] rv;
    if2.start = 1'b1; if2.dividend = a[1:0]; if2.divisor = b[1:0];
    sb2.push_back(model(a, b, 2));
    @(posedge clk); #1;
    if2.start = 1'b0; if2.dividend = 2'b11; if2.divisor = 2'b01;
    cyc = 0;
    while (if2.done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    x = sb2.pop_front();
    qv = x.q[1:0];
    rv = x.r[1:0];
    total++;
    if (if2.done !== 1'b1 || cyc !== x.lat) begin
      bad++; $display("FAIL latency2 %0d/%0d: done=%b cycles=%0d required 1 at %0d", a, b, if2.done, cyc, x.lat);
    end
    total++;
    if (if2.quotient !== qv || if2.remainder !== rv || if2.error !== x.e) begin
      bad++; $display("FAIL result2 %0d/%0d: got %0d r %0d e %b required %0d r %0d e %b",
                      a, b, if2.quotient, if2.remainder, if2.error, qv, rv, x.e);
    end
    @(posedge clk); #1;
    total++;
    if (if2.done !== 1'b0) begin
      bad++; $display("FAIL pulse2 %0d/%0d: done=%b required 0", a, b, if2.done);
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst2 = 1'b1;
    if8.start = 1'b1; if8.dividend = 8'd50; if8.divisor = 8'd3;
    if2.start = 1'b1; if2.dividend = 2'd3;  if2.divisor = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut8.state_q !== WAIT_FOR_START || dut2.state_q !== WAIT_FOR_START) begin
      bad++; $display("FAIL reset_state: got %0d/%0d required %0d", dut8.state_q, dut2.state_q, WAIT_FOR_START);
    end
    total++;
    if (if8.done !== 1'b0 || if8.error !== 1'b0 || if8.quotient !== 8'd0 || if8.remainder !== 8'd0) begin
      bad++; $display("FAIL reset_out8: done=%b error=%b q=%0d r=%0d required all 0",
                      if8.done, if8.error, if8.quotient, if8.remainder);
    end
    total++;
    if (if2.done !== 1'b0 || if2.error !== 1'b0 || if2.quotient !== 2'd0 || if2.remainder !== 2'd0) begin
      bad++; $display("FAIL reset_out2: done=%b error=%b q=%0d r=%0d required all 0",
                      if2.done, if2.error, if2.quotient, if2.remainder);
    end
    if8.start = 1'b0; if2.start = 1'b0;
    rst8 = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dut8.state_q !== WAIT_FOR_START) begin
      bad++; $display("FAIL reset_release: state=%0d required %0d", dut8.state_q, WAIT_FOR_START);
    end
  endtask

  task automatic test_div_by_zero();
    run8(37, 0, 1'b0);
  endtask

  task automatic test_basic();
    saw_sub_right = 1'b0;
    run8(200, 7, 1'b0);
    total++;
    if (saw_sub_right !== 1'b1) begin
      bad++; $display("FAIL sub_and_right: seen=%b required 1", saw_sub_right);
    end
    run8(100, 9, 1'b1);
  endtask

  task automatic test_boundary();
    run8(5, 9, 1'b0);
    run8(255, 1, 1'b0);
    run8(0, 3, 1'b0);
    run8(255, 255, 1'b0);
  endtask

  task automatic test_back_to_back();
    run2(2, 1);
    run2(0, 0);
    run2(3, 2);
    run2(1, 3);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit spurious;
    if8.start = 1'b1; if8.dividend = 8'd200; if8.divisor = 8'd7;
    @(posedge clk); #1;
    if8.start = 1'b0;
    cyc = 0;
    while (dut8.state_q !== SHIFT_RIGHT && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (dut8.state_q !== SHIFT_RIGHT) begin
      bad++; $display("FAIL reach_shift_right: state=%0d required %0d", dut8.state_q, SHIFT_RIGHT);
    end
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    total++;
    if (dut8.state_q !== WAIT_FOR_START || if8.done !== 1'b0 || if8.quotient !== 8'd0 || if8.remainder !== 8'd0) begin
      bad++; $display("FAIL mid_reset: state=%0d done=%b q=%0d r=%0d required %0d 0 0 0",
                      dut8.state_q, if8.done, if8.quotient, if8.remainder, WAIT_FOR_START);
    end
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (if8.done !== 1'b0) spurious = 1'b1;
    end
    total++;
    if (spurious !== 1'b0) begin
      bad++; $display("FAIL aborted_done: got done=1 required 0");
    end
    run8(9, 4, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    if8.start = 1'b0; if8.dividend = '0; if8.divisor = '0;
    if2.start = 1'b0; if2.dividend = '0; if2.divisor = '0;
    rst8 = 1'b1; rst2 = 1'b1;
    @(negedge clk);
    test_reset();
    test_div_by_zero();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
